alu_exec_stage: RTL

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// Two-stage ALU execute stage with valid/ready handshakes on both sides.
// S1 registers the operation; S2 holds the computed result until the consumer takes it.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             illegal_seen,
  output logic [15:0]      op_count
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  function automatic logic is_illegal(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: is_illegal = 1'b0;
      default:                               is_illegal = 1'b1;
    endcase
  endfunction

  // Unsupported codes fall through to zero, which the zero flag then reports.
  function automatic logic signed [WIDTH-1:0] alu_result(
    input logic [2:0]              op,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic                    vld_p1;
  logic [2:0]              ctrl_p1;
  logic signed [WIDTH-1:0] a_p1;
  logic signed [WIDTH-1:0] b_p1;

  logic                    vld_p2;
  logic signed [WIDTH-1:0] result_p2;
  logic                    zero_p2;
  logic                    illegal_p2;

  logic                    seen;
  logic [15:0]             count;

  logic                    in_hs;
  logic                    xfer_p1;
  logic                    out_hs;
  logic signed [WIDTH-1:0] alu_res_p1;

  assign out_hs   = vld_p2 && out_ready;
  assign xfer_p1  = vld_p1 && (!vld_p2 || out_hs);
  assign in_ready = rst_n && (!vld_p1 || xfer_p1);
  assign in_hs    = in_valid && in_ready;

  // ---- stage 1: operation capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (in_hs) begin
      vld_p1 <= 1'b1;
    end else if (xfer_p1) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs) begin
      ctrl_p1 <= alu_control;
      a_p1    <= src_a;
      b_p1    <= src_b;
    end
  end

  assign alu_res_p1 = alu_result(ctrl_p1, a_p1, b_p1);

  // ---- stage 2: result register, held while the consumer stalls ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2     <= 1'b0;
      result_p2  <= '0;
      zero_p2    <= 1'b0;
      illegal_p2 <= 1'b0;
    end else if (xfer_p1) begin
      vld_p2     <= 1'b1;
      result_p2  <= alu_res_p1;
      zero_p2    <= (alu_res_p1 == '0);
      illegal_p2 <= is_illegal(ctrl_p1);
    end else if (out_hs) begin
      vld_p2     <= 1'b0;
    end
  end

  // ---- handoff bookkeeping ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen  <= 1'b0;
      count <= 16'h0000;
    end else if (out_hs) begin
      count <= count + 16'd1;
      if (illegal_p2) begin
        seen <= 1'b1;
      end
    end
  end

  assign out_valid    = vld_p2;
  assign result       = result_p2;
  assign zero         = zero_p2;
  assign illegal      = illegal_p2;
  assign illegal_seen = seen;
  assign op_count     = count;

endmodule
